// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter that serializes loads/stores onto one data memory port.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module data_mem_arbiter #(
    parameter int BUS_WIDTH     = 64,
    parameter int MEM_BIT_WIDTH = 2,
    parameter int READ_LATENCY  = 1,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p0_req_valid,
    output logic                     p0_req_ready,
    input  logic                     p0_we,
    input  logic [BUS_WIDTH-1:0]     p0_addr,
    input  logic [BUS_WIDTH-1:0]     p0_wdata,
    input  logic [MEM_BIT_WIDTH-1:0] p0_bit_width,
    input  logic                     p0_sign_extend,
    output logic                     p0_rsp_valid,
    input  logic                     p0_rsp_ready,
    output logic [BUS_WIDTH-1:0]     p0_rdata,
    input  logic                     p1_req_valid,
    output logic                     p1_req_ready,
    input  logic                     p1_we,
    input  logic [BUS_WIDTH-1:0]     p1_addr,
    input  logic [BUS_WIDTH-1:0]     p1_wdata,
    input  logic [MEM_BIT_WIDTH-1:0] p1_bit_width,
    input  logic                     p1_sign_extend,
    output logic                     p1_rsp_valid,
    input  logic                     p1_rsp_ready,
    output logic [BUS_WIDTH-1:0]     p1_rdata,
    output logic                     mem_en,
    output logic                     mem_wea,
    output logic [BUS_WIDTH-1:0]     mem_addr,
    output logic [BUS_WIDTH-1:0]     mem_din,
    output logic [MEM_BIT_WIDTH-1:0] mem_bit_width,
    output logic                     mem_sign_extend,
    input  logic [BUS_WIDTH-1:0]     mem_dout,
    output logic [STAT_WIDTH-1:0]    stat_gnt0,
    output logic [STAT_WIDTH-1:0]    stat_gnt1,
    output logic [STAT_WIDTH-1:0]    stat_conflict
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t                   state_q;
    logic                     owner_q;
    logic                     last_q;
    logic                     we_q;
    logic [1:0]               cnt_q;
    logic                     mem_en_q;
    logic                     mem_wea_q;
    logic [BUS_WIDTH-1:0]     mem_addr_q;
    logic [BUS_WIDTH-1:0]     mem_din_q;
    logic [MEM_BIT_WIDTH-1:0] mem_bw_q;
    logic                     mem_sext_q;
    logic                     rsp_valid0_q;
    logic                     rsp_valid1_q;
    logic [BUS_WIDTH-1:0]     rdata0_q;
    logic [BUS_WIDTH-1:0]     rdata1_q;

    logic                     gnt0;
    logic                     gnt1;
    logic                     owner_rsp_ready;
    logic                     sel_we;
    logic [BUS_WIDTH-1:0]     sel_addr;
    logic [BUS_WIDTH-1:0]     sel_wdata;
    logic [MEM_BIT_WIDTH-1:0] sel_bw;
    logic                     sel_sext;

    // last_q == 1 means port 1 was granted last, so port 0 wins the next tie.
    // Grants are gated by rst_n so req_ready reads 0 while reset is held.
    assign gnt0 = rst_n && (state_q == IDLE) && p0_req_valid && (!p1_req_valid || last_q);
    assign gnt1 = rst_n && (state_q == IDLE) && p1_req_valid && (!p0_req_valid || !last_q);

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    assign sel_we    = gnt1 ? p1_we          : p0_we;
    assign sel_addr  = gnt1 ? p1_addr        : p0_addr;
    assign sel_wdata = gnt1 ? p1_wdata       : p0_wdata;
    assign sel_bw    = gnt1 ? p1_bit_width   : p0_bit_width;
    assign sel_sext  = gnt1 ? p1_sign_extend : p0_sign_extend;

    assign owner_rsp_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_wea_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_bw_q     <= '0;
            mem_sext_q   <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner_q    <= gnt1;
                        last_q     <= gnt1;
                        we_q       <= sel_we;
                        mem_addr_q <= sel_addr;
                        mem_din_q  <= sel_wdata;
                        mem_bw_q   <= sel_bw;
                        mem_sext_q <= sel_sext;
                        mem_en_q   <= 1'b1;
                        mem_wea_q  <= sel_we;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q     <= '0;
                    mem_wea_q <= 1'b0;
                    if (we_q) begin
                        mem_en_q <= 1'b0;
                        if (owner_q) begin
                            rdata1_q     <= '0;
                            rsp_valid1_q <= 1'b1;
                        end else begin
                            rdata0_q     <= '0;
                            rsp_valid0_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        mem_en_q <= 1'b0;
                        if (owner_q) begin
                            rdata1_q     <= mem_dout;
                            rsp_valid1_q <= 1'b1;
                        end else begin
                            rdata0_q     <= mem_dout;
                            rsp_valid0_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp_valid0_q <= 1'b0;
                        rsp_valid1_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en          = mem_en_q;
    assign mem_wea         = mem_wea_q;
    assign mem_addr        = mem_addr_q;
    assign mem_din         = mem_din_q;
    assign mem_bit_width   = mem_bw_q;
    assign mem_sign_extend = mem_sext_q;
    assign p0_rsp_valid    = rsp_valid0_q;
    assign p1_rsp_valid    = rsp_valid1_q;
    assign p0_rdata        = rdata0_q;
    assign p1_rdata        = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] gnt0_cnt_q;
    logic [STAT_WIDTH-1:0] gnt1_cnt_q;
    logic [STAT_WIDTH-1:0] conflict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt_q     <= '0;
            gnt1_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt0) gnt0_cnt_q <= gnt0_cnt_q + 1'b1;
            if (gnt1) gnt1_cnt_q <= gnt1_cnt_q + 1'b1;
            if ((gnt0 || gnt1) && p0_req_valid && p1_req_valid)
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign stat_gnt0     = gnt0_cnt_q;
    assign stat_gnt1     = gnt1_cnt_q;
    assign stat_conflict = conflict_cnt_q;
`else
    assign stat_gnt0     = '0;
    assign stat_gnt1     = '0;
    assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a byte-lane memory model behind the memory port.
// Stat expectations follow DMEM_ARB_STATS_EN.
module tb_data_mem_arbiter;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_valid = 0, p0_we = 0, p0_sign_extend = 0, p0_rsp_ready = 1;
    logic        p1_req_valid = 0, p1_we = 0, p1_sign_extend = 0, p1_rsp_ready = 1;
    logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [1:0]  p0_bit_width = 0, p1_bit_width = 0;
    logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_wea, mem_sign_extend;
    logic [63:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_bit_width;
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    logic [7:0]  mem_arr [256];
    logic [7:0]  ref_mem [256];
    logic [63:0] rd_pipe [RL];

    data_mem_arbiter #(.BUS_WIDTH(64), .MEM_BIT_WIDTH(2), .READ_LATENCY(RL), .STAT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_bit_width(p0_bit_width),
        .p0_sign_extend(p0_sign_extend), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rdata(p0_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_bit_width(p1_bit_width),
        .p1_sign_extend(p1_sign_extend), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_bit_width(mem_bit_width), .mem_sign_extend(mem_sign_extend),
        .mem_dout(mem_dout),
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_read(input logic [7:0] m [256], input logic [63:0] a,
                                             input logic [1:0] bw, input logic se);
        logic [63:0] v;
        int n;
        v = '0;
        n = 1 << bw;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m[8'(a[7:0] + 8'(i))];
        if (se && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] bw);
        for (int i = 0; i < (1 << bw); i++) ref_mem[8'(a[7:0] + 8'(i))] = d[8*i +: 8];
    endtask

    // Memory model: writes on en&wea, reads delivered RL cycles after an enabled read edge.
    always @(posedge clk) begin
        if (mem_en && mem_wea)
            for (int i = 0; i < (1 << mem_bit_width); i++)
                mem_arr[8'(mem_addr[7:0] + 8'(i))] <= mem_din[8*i +: 8];
        if (mem_en && !mem_wea)
            rd_pipe[0] <= mem_read(mem_arr, mem_addr, mem_bit_width, mem_sign_extend);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RL-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && p0_rsp_valid && p0_rsp_ready) begin
            if (q0.size() == 0) check("p0_rsp_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                $display("t=%0t p0 rsp rdata=%h exp=%h", $time, p0_rdata, e);
                check("p0_rdata", p0_rdata, e);
            end
        end
        if (rst_n && p1_rsp_valid && p1_rsp_ready) begin
            if (q1.size() == 0) check("p1_rsp_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                $display("t=%0t p1 rsp rdata=%h exp=%h", $time, p1_rdata, e);
                check("p1_rdata", p1_rdata, e);
            end
        end
    end

    task automatic set_req(input bit port, input bit v, input bit we, input logic [63:0] a,
                           input logic [63:0] d, input logic [1:0] bw, input bit se);
        if (port) begin
            p1_req_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_bit_width = bw; p1_sign_extend = se;
        end else begin
            p0_req_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_bit_width = bw; p0_sign_extend = se;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        p0_req_valid = 1'b1;
        @(negedge clk);
        check("rst_p0_req_ready", p0_req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
        check("rst_stat", {stat_gnt0, stat_gnt1}, 0);
        p0_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(q0.size() + q1.size()), 0);
    endtask

    // One isolated access; checks response latency and the memory-port activity it causes.
    task automatic single(input bit port, input bit we, input logic [63:0] a,
                          input logic [63:0] d, input logic [1:0] bw, input bit se);
        logic [63:0] e;
        bit hs, got_rsp, addr_bad;
        int n, en_cnt, wea_cnt;
        e = we ? 64'd0 : mem_read(ref_mem, a, bw, se);
        if (we) ref_write(a, d, bw);
        @(posedge clk); #1;
        set_req(port, 1, we, a, d, bw, se);
        hs = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (port ? p1_req_ready : p0_req_ready) begin hs = 1; break; end
        end
        if (!hs) begin
            check("req_timeout", 0, 1);
            set_req(port, 0, 0, 0, 0, 0, 0);
            return;
        end
        if (port) q1.push_back(e); else q0.push_back(e);
        @(posedge clk); #1;
        set_req(port, 0, 0, 0, 0, 0, 0);
        n = 0; en_cnt = 0; wea_cnt = 0; addr_bad = 0; got_rsp = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (mem_en) begin
                en_cnt++;
                if (mem_wea) wea_cnt++;
                if (mem_addr != a) addr_bad = 1;
            end
            if (port ? p1_rsp_valid : p0_rsp_valid) begin got_rsp = 1; break; end
        end
        check("rsp_seen", 64'(got_rsp), 1);
        check("rsp_latency", 64'(n), we ? 64'd2 : 64'(2 + RL));
        check("mem_en_cycles", 64'(en_cnt), we ? 64'd1 : 64'(1 + RL));
        check("mem_wea_cycles", 64'(wea_cnt), we ? 64'd1 : 64'd0);
        check("mem_addr_held", 64'(addr_bad), 0);
        wait_drain();
    endtask

    initial begin
        int grants, port_seen;
        bit seen, stray;
        logic [63:0] e;
        for (int i = 0; i < 256; i++) begin mem_arr[i] = 8'h00; ref_mem[i] = 8'h00; end
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

        #1;
        do_reset();

        // Store then reads of the same location at different sizes.
        single(0, 1, 64'h10, 64'h1122334455667788, 2'b11, 0);
        single(0, 0, 64'h10, 0, 2'b11, 0);
        single(0, 0, 64'h10, 0, 2'b00, 1);
        single(1, 0, 64'h11, 0, 2'b01, 0);
        single(1, 1, 64'h33, 64'h0000_0000_0000_80F1, 2'b01, 0);
        single(0, 0, 64'h33, 0, 2'b01, 1);

        // Continuous contention: grants must alternate starting at port 0.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1, 0, 64'h10, 0, 2'b11, 0);
        set_req(1, 1, 0, 64'h10, 0, 2'b00, 1);
        grants = 0;
        for (int k = 0; k < 300 && grants < 5; k++) begin
            @(negedge clk);
            if (p0_req_ready && p1_req_ready) check("both_ready", 1, 0);
            port_seen = -1;
            if (p0_req_ready) begin port_seen = 0; q0.push_back(mem_read(ref_mem, 64'h10, 2'b11, 0)); end
            else if (p1_req_ready) begin port_seen = 1; q1.push_back(mem_read(ref_mem, 64'h10, 2'b00, 1)); end
            if (port_seen >= 0) begin
                $display("t=%0t grant %0d to port %0d", $time, grants, port_seen);
                check("gnt_order", 64'(port_seen), 64'(grants % 2));
                grants++;
            end
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        check("grant_count", 64'(grants), 5);
        wait_drain();
`ifdef DMEM_ARB_STATS_EN
        check("stat_gnt0", stat_gnt0, 3);
        check("stat_gnt1", stat_gnt1, 2);
        check("stat_conflict", stat_conflict, 5);
`else
        check("stat_gnt0", stat_gnt0, 0);
        check("stat_gnt1", stat_gnt1, 0);
        check("stat_conflict", stat_conflict, 0);
`endif

        // Port 1 response back-pressured while port 0 waits.
        p1_rsp_ready = 1'b0;
        e = mem_read(ref_mem, 64'h10, 2'b11, 0);
        @(posedge clk); #1;
        set_req(1, 1, 0, 64'h10, 0, 2'b11, 0);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (p1_req_ready) begin seen = 1; break; end
        end
        check("bp_p1_grant", 64'(seen), 1);
        q1.push_back(e);
        @(posedge clk); #1;
        set_req(1, 0, 0, 0, 0, 0, 0);
        set_req(0, 1, 1, 64'h20, 64'hA5A5_0000_1234_FEDC, 2'b11, 0);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (p0_req_ready) check("bp_p0_early_ready", 1, 0);
            if (p1_rsp_valid) begin seen = 1; break; end
        end
        check("bp_rsp_seen", 64'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid_held", 64'(p1_rsp_valid), 1);
            check("bp_rdata_held", p1_rdata, e);
            check("bp_p0_ready_low", 64'(p0_req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        p1_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_p0_ready_in_resp", 64'(p0_req_ready), 0);
        @(negedge clk);
        check("bp_p0_ready_after", 64'(p0_req_ready), 1);
        q0.push_back(64'd0);
        ref_write(64'h20, 64'hA5A5_0000_1234_FEDC, 2'b11);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        wait_drain();
        single(1, 0, 64'h20, 0, 2'b10, 1);

        // Reset pulse during WAIT aborts the load without a response.
        @(posedge clk); #1;
        set_req(0, 1, 0, 64'h10, 0, 2'b11, 0);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (p0_req_ready) begin seen = 1; break; end
        end
        check("rw_grant", 64'(seen), 1);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("rw_in_wait", 64'(mem_en && !mem_wea), 1);
        #1;
        rst_n = 1'b0;
        p1_req_valid = 1'b1;
        #1;
        check("rw_mem_en", {mem_en, mem_wea}, 0);
        check("rw_mem_addr", mem_addr, 0);
        check("rw_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
        check("rw_req_ready", {p0_req_ready, p1_req_ready}, 0);
        @(posedge clk); #1;
        p1_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) stray = 1;
        end
        check("rw_no_rsp", 64'(stray), 0);
        single(0, 0, 64'h10, 0, 2'b11, 0);

        check("queues_empty", 64'(q0.size() + q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and access sequencer in front of the byte-lane data memory unit. It sits between the core load/store path (port 0) and a secondary master such as a loader or debug engine (port 1). Each access is serialized onto the single memory port and issued at the memory's fixed read latency. The result, read data or write acknowledge, is returned to the owning requester over a valid/ready handshake.

## Interface
- BUS_WIDTH, 64: address/data width; equals the memory unit's bus width.
- MEM_BIT_WIDTH, 2: access-size field width (00 byte, 01 half, 10 word, 11 double).
- READ_LATENCY, 1: cycles from memory enable to valid read data; legal range 1..4.
- STAT_WIDTH, 32: width of statistics counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pN_req_valid  in  1  port N (N=0,1) request present.
- pN_req_ready  out  1  port N request accepted this cycle.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  BUS_WIDTH  byte address; misaligned is allowed and handled by the memory unit.
- pN_wdata  in  BUS_WIDTH  store data, right-aligned.
- pN_bit_width  in  MEM_BIT_WIDTH  access size.
- pN_sign_extend  in  1  load sign extension.
- pN_rsp_valid  out  1  response available to port N.
- pN_rsp_ready  in  1  port N consumes the response.
- pN_rdata  out  BUS_WIDTH  load data; 0 for store acknowledges.
- mem_en, mem_wea  out  1  memory enable / write enable.
- mem_addr, mem_din  out  BUS_WIDTH  registered address / write data.
- mem_bit_width  out  MEM_BIT_WIDTH; mem_sign_extend  out  1.
- mem_dout  in  BUS_WIDTH  memory read data.
- stat_gnt0, stat_gnt1, stat_conflict  out  STAT_WIDTH  statistics (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among asserted pN_req_valid.
  - pN_req_ready is high only for the winner, only in IDLE, and combinationally from the valids.
  - On handshake, register owner, we, addr, wdata, bit_width and sign_extend, then go to ISSUE.
- Round-robin arbitration:
  - A lone requester always wins.
  - When both request, the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first conflict.
- ISSUE (1 cycle):
  - mem_en=1; mem_wea=registered we; mem_* driven from registers.
  - A store goes to RESP. A load goes to WAIT.
- WAIT (READ_LATENCY cycles):
  - mem_en=1, mem_wea=0, address held.
  - At the edge ending the last WAIT cycle, capture mem_dout into the owner's rdata register, then go to RESP.
- RESP:
  - Owner's pN_rsp_valid=1, with pN_rdata stable (0 for stores).
  - When pN_rsp_ready=1, go to IDLE.
  - A non-owner rsp_ready is ignored.
- mem_en and mem_wea are 0 in IDLE and RESP. The mem_addr/din registers hold their last value.
- Only one access is ever in flight. Requests arriving outside IDLE wait with req_ready=0 and must hold valid and payload.

## Timing
- Reset (async assert, sync-safe deassert): all outputs 0, FSM IDLE, counters 0, pointer 1.
- Reset mid-operation aborts the access. No response is produced, and a partially issued store is the only memory side effect.
- Handshake at edge E0 → ISSUE in cycle 1.
- Store: rsp_valid from cycle 2.
- Load: rsp_valid from cycle 2+READ_LATENCY.
- If rsp_ready is already high, IDLE resumes the next cycle. Back-to-back throughput is 1 access per 3 (store) or 3+READ_LATENCY (load) cycles.
- rsp_valid stays high and rdata stable until the rsp_ready handshake.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - stat_gnt0 and stat_gnt1 increment on each port handshake.
  - stat_conflict increments on each IDLE cycle where both valids are high and a grant occurs.
  - All counters wrap modulo 2^STAT_WIDTH.
- Not defined: counters are not built and the stat_* outputs are tied to 0.

## Test plan
- Port 0 store of 0x1122334455667788, double, addr 0x10, then load back with READ_LATENCY=1 → store rsp at cycle 2 with rdata 0; load rsp at cycle 3 with rdata 0x1122334455667788.
- Both ports request continuously with loads → grants alternate 0,1,0,1; first grant goes to port 0; stat_conflict equals the grant count.
- Port 1 load with rsp_ready held low for 5 cycles → rsp_valid and rdata held stable; port 0 req_ready stays 0 throughout; IDLE is entered one cycle after rsp_ready rises.
- READ_LATENCY=3 load → mem_en high for 4 cycles with mem_wea=0 and constant mem_addr; rsp_valid rises at cycle 5.
- rst_n pulsed low during WAIT → all outputs 0 immediately; no rsp_valid afterwards; next request is serviced normally.
- Stats with macro defined, after 3 port-0 and 2 port-1 grants → stat_gnt0=3, stat_gnt1=2. Without the macro, all stat_* outputs read 0.
